// File: rtl/elastic_group_sum.sv
// Accumulates groups of up to GROUP input words (closed early by t0_last) into one
// zero-extended sum plus beat count, presented on a registered valid/ready output.
module elastic_group_sum #(
  parameter  int DW    = 32,
  parameter  int GROUP = 4,
  localparam int SW    = DW + $clog2(GROUP),
  localparam int CW    = $clog2(GROUP + 1)
) (
  input  logic          clk,
  input  logic          rstf,
  input  logic [DW-1:0] t0_data,
  input  logic          t0_valid,
  input  logic          t0_last,
  output logic          t0_ready,
  output logic [SW-1:0] i0_data,
  output logic [CW-1:0] i0_beats,
  output logic          i0_valid,
  input  logic          i0_ready
);

  logic [SW-1:0] acc_r;
  logic [CW-1:0] cnt_r;
  logic          accept_s;
  logic          xfer_s;
  logic          closing_s;
  logic [SW-1:0] sum_n_s;

  // Handshake decode and next-sum datapath.
  always_comb begin
    t0_ready  = ~i0_valid | i0_ready;
    accept_s  = t0_valid & t0_ready;
    xfer_s    = i0_valid & i0_ready;
    closing_s = t0_last | (cnt_r == CW'(GROUP - 1));
    if (cnt_r == {CW{1'b0}}) begin
      sum_n_s = SW'(t0_data);
    end else begin
      sum_n_s = acc_r + SW'(t0_data);
    end
  end

  // Accumulator, beat counter and output register; a partial group is dropped on reset.
  always_ff @(posedge clk or negedge rstf) begin
    if (!rstf) begin
      acc_r    <= {SW{1'b0}};
      cnt_r    <= {CW{1'b0}};
      i0_data  <= {SW{1'b0}};
      i0_beats <= {CW{1'b0}};
      i0_valid <= 1'b0;
    end else begin
      if (accept_s && closing_s) begin
        // A closing beat may coincide with the transfer of the previous result.
        i0_data  <= sum_n_s;
        i0_beats <= cnt_r + CW'(1'b1);
        i0_valid <= 1'b1;
        acc_r    <= {SW{1'b0}};
        cnt_r    <= {CW{1'b0}};
      end else if (accept_s) begin
        acc_r <= sum_n_s;
        cnt_r <= cnt_r + CW'(1'b1);
        if (xfer_s) begin
          i0_valid <= 1'b0;
        end
      end else if (xfer_s) begin
        i0_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_elastic_group_sum.sv
// Scoreboard bench for elastic_group_sum: GROUP=4 and GROUP=1 instances share stimulus.
module tb_elastic_group_sum;

  logic        clk = 1'b0;
  logic        rstf = 1'b0;
  logic [31:0] t0_data = 32'd0;
  logic        t0_valid = 1'b0;
  logic        t0_last = 1'b0;
  logic        i0_ready = 1'b0;

  logic        rdy0, v0;
  logic [33:0] d0;
  logic [2:0]  b0;
  logic        rdy1, v1;
  logic [31:0] d1;
  logic        b1;

  int          n_checks = 0;
  int          n_fail = 0;
  logic [36:0] exp_q[$];
  bit          sel = 1'b0;
  bit          toggle_en = 1'b0;
  int          group_m = 4;
  logic [33:0] m_acc = 34'd0;
  int          m_cnt = 0;
  int          last_wait = 0;

  elastic_group_sum #(.DW(32), .GROUP(4)) dut4 (
    .clk(clk), .rstf(rstf), .t0_data(t0_data), .t0_valid(t0_valid), .t0_last(t0_last),
    .t0_ready(rdy0), .i0_data(d0), .i0_beats(b0), .i0_valid(v0), .i0_ready(i0_ready));

  elastic_group_sum #(.DW(32), .GROUP(1)) dut1 (
    .clk(clk), .rstf(rstf), .t0_data(t0_data), .t0_valid(t0_valid), .t0_last(t0_last),
    .t0_ready(rdy1), .i0_data(d1), .i0_beats(b1), .i0_valid(v1), .i0_ready(i0_ready));

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic pop_cmp(input string tag, input logic [36:0] got);
    logic [36:0] e;
    if (exp_q.size() == 0) begin
      check({tag, "_unexpected"}, 64'd1, 64'd0);
    end else begin
      e = exp_q.pop_front();
      check(tag, 64'(got), 64'(e));
    end
  endtask

  // Output monitor: every transfer is compared with the oldest expected result.
  always @(negedge clk) begin
    if (rstf && i0_ready) begin
      if (!sel && v0) pop_cmp("out_g4", {d0, b0});
      else if (sel && v1) pop_cmp("out_g1", {2'b00, d1, 2'b00, b1});
    end
  end

  always @(posedge clk) begin
    if (toggle_en) begin
      #1;
      i0_ready = ~i0_ready;
    end
  end

  task automatic model_reset();
    m_acc = 34'd0;
    m_cnt = 0;
  endtask

  // Present one word until accepted; the reference model updates on acceptance.
  task automatic send(input logic [31:0] d, input logic last);
    logic [33:0] s;
    bit          rdy;
    int          n;
    t0_data  = d;
    t0_last  = last;
    t0_valid = 1'b1;
    n = 0;
    rdy = 1'b0;
    while (!rdy && n <= 200) begin
      @(negedge clk);
      rdy = sel ? rdy1 : rdy0;
      if (!rdy) n++;
    end
    last_wait = n;
    if (!rdy) begin
      check("send_timeout", 64'd1, 64'd0);
    end else begin
      s = (m_cnt == 0) ? 34'(d) : m_acc + 34'(d);
      if (last || m_cnt == group_m - 1) begin
        exp_q.push_back({s, 3'(m_cnt + 1)});
        model_reset();
      end else begin
        m_acc = s;
        m_cnt = m_cnt + 1;
      end
      @(posedge clk);
    end
    #1;
    t0_valid = 1'b0;
    t0_last  = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    #2;
    check("rst_valid4", 64'(v0), 64'd0);
    check("rst_data4", 64'(d0), 64'd0);
    check("rst_beats4", 64'(b0), 64'd0);
    check("rst_valid1", 64'(v1), 64'd0);
    @(posedge clk); #1;
    rstf = 1'b1;
    i0_ready = 1'b1;

    // Full group of 1..4, back-to-back, one-cycle valid pulse
    for (int i = 1; i <= 4; i++) begin
      send(32'(i), 1'b0);
      check("t1_ready", 64'(last_wait), 64'd0);
    end
    @(negedge clk);
    check("t1_valid_hi", 64'(v0), 64'd1);
    @(negedge clk);
    check("t1_valid_lo", 64'(v0), 64'd0);
    idle(1);

    // Maximum words: no truncation
    for (int i = 0; i < 4; i++) send(32'hFFFF_FFFF, 1'b0);
    idle(2);

    // Early close then full group
    send(32'd5, 1'b0);
    send(32'd7, 1'b1);
    for (int i = 0; i < 4; i++) send(32'd1, 1'b0);
    idle(2);

    // Backpressure: result held, input stalled
    i0_ready = 1'b0;
    for (int i = 1; i <= 4; i++) send(32'(i), 1'b0);
    t0_data  = 32'd6;
    t0_last  = 1'b1;
    t0_valid = 1'b1;
    repeat (10) begin
      @(negedge clk);
      check("t4_ready_lo", 64'(rdy0), 64'd0);
      check("t4_hold_data", 64'(d0), 64'd10);
      check("t4_hold_beats", 64'(b0), 64'd4);
      check("t4_hold_valid", 64'(v0), 64'd1);
    end
    @(posedge clk); #1;
    i0_ready = 1'b1;
    send(32'd6, 1'b1);
    check("t4_resume", 64'(last_wait), 64'd0);
    idle(2);

    // Asynchronous reset mid-group discards the partial sum
    send(32'd3, 1'b0);
    send(32'd3, 1'b0);
    #3;
    rstf = 1'b0;
    #1;
    check("t5_rst_data", 64'(d0), 64'd0);
    check("t5_rst_beats", 64'(b0), 64'd0);
    check("t5_rst_valid", 64'(v0), 64'd0);
    model_reset();
    idle(2);
    rstf = 1'b1;
    for (int i = 0; i < 4; i++) send(32'd1, 1'b0);
    idle(2);

    // GROUP=1 instance with toggling downstream ready
    rstf = 1'b0;
    idle(2);
    rstf = 1'b1;
    sel = 1'b1;
    group_m = 1;
    model_reset();
    i0_ready = 1'b1;
    toggle_en = 1'b1;
    send(32'd9, 1'b0);
    send(32'd8, 1'b0);
    send(32'd7, 1'b0);
    for (int n = 0; n < 50 && exp_q.size() != 0; n++) @(posedge clk);
    toggle_en = 1'b0;
    #2;
    i0_ready = 1'b1;
    idle(3);

    check("queue_drained", 64'(exp_q.size()), 64'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
